// File: rtl/bin_to_bcd_serial.sv
// Serial binary-to-BCD converter (double-dabble, one bit per clock).
// Accepts unsigned or two's-complement input, produces packed BCD digits,
// a sign flag and per-digit leading-zero blanking for the display decoders.
module bin_to_bcd_serial #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Signed,
    input  logic [WIDTH-1:0]      Bin,
    output logic                  Busy,
    output logic                  Done,
    output logic [4*DIGITS-1:0]   Bcd,
    output logic                  Sign,
    output logic [DIGITS-1:0]     Blank
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // Display reads "0": every digit above the units is blanked.
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    // The digit count must hold the largest magnitude, so overflow is impossible.
    generate
        if (10 ** DIGITS <= 2 ** WIDTH) begin : g_digits_check
            $error("bin_to_bcd_serial: DIGITS too small for WIDTH");
        end
    endgenerate

    logic [0:0]          state;
    logic [CW-1:0]       cnt;
    logic [BW-1:0]       bcd_acc;
    logic [WIDTH-1:0]    bin_sh;
    logic                neg;

    logic                in_neg;
    logic [WIDTH-1:0]    mag;
    logic [BW-1:0]       adj;
    logic [BW+WIDTH-1:0] cat_nx;
    logic [BW-1:0]       acc_nx;
    logic [WIDTH-1:0]    sh_nx;
    logic [DIGITS-1:0]   blank_nx;
    logic                zero_above;

    // Magnitude of the input; -2^(WIDTH-1) maps to 2^(WIDTH-1) by modular negation.
    assign in_neg = Signed & Bin[WIDTH-1];
    assign mag    = in_neg ? (~Bin + WIDTH'(1)) : Bin;

    assign Busy = (state == SHIFT);

    // Add-3 correction on every digit that is 5 or more, ahead of the shift.
    always_comb begin
        adj = bcd_acc;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_acc[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = bcd_acc[4*k +: 4] + 4'd3;
        end
    end

    assign cat_nx = {adj, bin_sh} << 1;
    assign acc_nx = cat_nx[BW+WIDTH-1 -: BW];
    assign sh_nx  = cat_nx[WIDTH-1:0];

    // Digit k is blanked when it and every higher digit are zero; units never blank.
    always_comb begin
        blank_nx   = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above  = zero_above & (acc_nx[4*k +: 4] == 4'd0);
            blank_nx[k] = zero_above;
        end
    end

    // Control FSM, working registers and the output registers updated on Done.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bcd_acc <= '0;
            bin_sh  <= '0;
            neg     <= 1'b0;
            Done    <= 1'b0;
            Bcd     <= '0;
            Sign    <= 1'b0;
            Blank   <= BLANK_RST;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        bcd_acc <= '0;
                        bin_sh  <= mag;
                        neg     <= in_neg;
                        cnt     <= CW'(WIDTH);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_acc <= acc_nx;
                    bin_sh  <= sh_nx;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        Bcd   <= acc_nx;
                        Sign  <= neg;
                        Blank <= blank_nx;
                        Done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Self-checking bench for bin_to_bcd_serial (WIDTH=8, DIGITS=3) using a
// scoreboard queue: expected results are pushed at Start, popped on Done.
module tb_bin_to_bcd_serial;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    typedef struct {
        logic [4*DIGITS-1:0] bcd;
        logic                sign;
        logic [DIGITS-1:0]   blank;
    } exp_t;

    logic                Clock = 1'b0;
    logic                Reset = 1'b0;
    logic                Start = 1'b0;
    logic                Signed = 1'b0;
    logic [WIDTH-1:0]    Bin = '0;
    logic                Busy;
    logic                Done;
    logic [4*DIGITS-1:0] Bcd;
    logic                Sign;
    logic [DIGITS-1:0]   Blank;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    exp_t sb[$];

    bin_to_bcd_serial #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Signed(Signed), .Bin(Bin),
        .Busy(Busy), .Done(Done), .Bcd(Bcd), .Sign(Sign), .Blank(Blank)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // Reference model: decimal digits by division, blanking by magnitude thresholds.
    function automatic exp_t model(input logic [WIDTH-1:0] b, input logic s);
        exp_t e;
        int v, p;
        e.sign = s && b[WIDTH-1];
        v = e.sign ? (256 - int'(b)) : int'(b);
        e.bcd = '0;
        p = v;
        for (int k = 0; k < DIGITS; k++) begin
            e.bcd[4*k +: 4] = 4'(p % 10);
            p = p / 10;
        end
        e.blank = '0;
        e.blank[1] = (v < 10);
        e.blank[2] = (v < 100);
        return e;
    endfunction

    // Scoreboard monitor: every Done must match the oldest pending expectation.
    always @(negedge Clock) begin
        if (Done) begin
            exp_t e;
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            checks = checks + 1;
            if (Busy) begin
                errors = errors + 1;
                $display("FAIL done_with_busy: Busy=%0b required 0", Busy);
            end
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_done: Bcd=%h with no pending conversion", Bcd);
            end else begin
                e = sb.pop_front();
                if (Bcd !== e.bcd || Sign !== e.sign || Blank !== e.blank) begin
                    errors = errors + 1;
                    $display("FAIL result: Bcd=%h Sign=%b Blank=%b required Bcd=%h Sign=%b Blank=%b",
                             Bcd, Sign, Blank, e.bcd, e.sign, e.blank);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #2;
    endtask

    // Issue a one-cycle Start; returns the index of the sampling edge.
    task automatic start_conv(input logic [WIDTH-1:0] b, input logic s, output int e0);
        Bin = b; Signed = s; Start = 1'b1;
        sb.push_back(model(b, s));
        tick(1);
        e0 = cyc;
        Start = 1'b0;
    endtask

    // Wait (bounded) for the next Done.
    task automatic wait_done(input string name);
        int n0;
        n0 = done_cnt;
        for (int i = 0; i < 40 && done_cnt == n0; i++) tick(1);
        checks = checks + 1;
        if (done_cnt == n0) begin
            errors = errors + 1;
            $display("FAIL %s_timeout: no Done within 40 cycles", name);
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        #3;
        checks = checks + 1;
        if (Busy !== 1'b0 || Done !== 1'b0 || Bcd !== 12'h000 || Sign !== 1'b0 || Blank !== 3'b110) begin
            errors = errors + 1;
            $display("FAIL reset_state: Busy=%b Done=%b Bcd=%h Sign=%b Blank=%b required 0 0 000 0 110",
                     Busy, Done, Bcd, Sign, Blank);
        end
        tick(2);
        Reset = 1'b0;
        tick(1);
    endtask

    task automatic test_unsigned_255;
        int e0;
        start_conv(8'd255, 1'b0, e0);
        checks = checks + 1;
        if (Busy !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL busy_after_start: Busy=%b required 1", Busy);
        end
        wait_done("u255");
        checks = checks + 1;
        if (done_cyc - e0 != WIDTH) begin
            errors = errors + 1;
            $display("FAIL latency: %0d cycles required %0d", done_cyc - e0, WIDTH);
        end
        tick(1);
        checks = checks + 1;
        if (Done !== 1'b0 || Bcd !== 12'h255) begin
            errors = errors + 1;
            $display("FAIL done_single_cycle: Done=%b Bcd=%h required 0 255", Done, Bcd);
        end
    endtask

    task automatic test_small_values;
        int e0;
        logic [WIDTH-1:0] vals [3] = '{8'd0, 8'd9, 8'd10};
        foreach (vals[i]) begin
            start_conv(vals[i], 1'b0, e0);
            wait_done("small");
            tick(1);
        end
    endtask

    task automatic test_signed;
        int e0;
        logic [WIDTH-1:0] vals [4] = '{8'h80, 8'hFF, 8'h7F, 8'h9C};
        foreach (vals[i]) begin
            start_conv(vals[i], 1'b1, e0);
            wait_done("signed");
            tick(1);
        end
        // Unsigned interpretation of a high-bit value.
        start_conv(8'h80, 1'b0, e0);
        wait_done("unsigned_hi");
        tick(1);
    endtask

    task automatic test_start_while_busy;
        int e0, n0;
        logic [4*DIGITS-1:0] prev;
        prev = Bcd;
        n0 = done_cnt;
        start_conv(8'd200, 1'b0, e0);
        tick(2);
        Bin = 8'd5; Signed = 1'b1; Start = 1'b1;
        tick(1);
        Start = 1'b0;
        checks = checks + 1;
        if (Bcd !== prev || Busy !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL busy_outputs_stable: Bcd=%h Busy=%b required %h 1", Bcd, Busy, prev);
        end
        wait_done("busy_start");
        tick(15);
        checks = checks + 1;
        if (done_cnt - n0 != 1) begin
            errors = errors + 1;
            $display("FAIL busy_start_done_count: %0d Done pulses required 1", done_cnt - n0);
        end
    endtask

    task automatic test_reset_mid;
        int e0, n0;
        start_conv(8'd77, 1'b0, e0);
        tick(3);
        Reset = 1'b1;
        #1;
        checks = checks + 1;
        if (Busy !== 1'b0 || Done !== 1'b0 || Bcd !== 12'h000 || Sign !== 1'b0 || Blank !== 3'b110) begin
            errors = errors + 1;
            $display("FAIL reset_mid: Busy=%b Done=%b Bcd=%h Sign=%b Blank=%b required 0 0 000 0 110",
                     Busy, Done, Bcd, Sign, Blank);
        end
        sb.delete();
        n0 = done_cnt;
        tick(2);
        Reset = 1'b0;
        tick(15);
        checks = checks + 1;
        if (done_cnt != n0) begin
            errors = errors + 1;
            $display("FAIL reset_mid_no_done: %0d Done pulses required 0", done_cnt - n0);
        end
        start_conv(8'd163, 1'b0, e0);
        wait_done("after_reset");
        tick(1);
    endtask

    task automatic test_back_to_back;
        Start = 1'b1; Signed = 1'b0;
        for (int i = 0; i < 256; i++) begin
            Bin = 8'(i);
            sb.push_back(model(8'(i), 1'b0));
            tick(1);
            Bin = ~8'(i);
            tick(WIDTH);
            checks = checks + 1;
            if (Done !== 1'b1) begin
                errors = errors + 1;
                $display("FAIL b2b_cadence: Done=%b required 1 for Bin=%0d", Done, i);
            end
        end
        Start = 1'b0;
        tick(12);
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL b2b_drain: %0d results pending required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_255();
        test_small_values();
        test_signed();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
